// File: rtl/strobe_gen.sv
// strobe_gen: programmable enable-strobe generator.
// After an accepted start, waits `offset` cycles and then emits a one-cycle
// `en` every `interval+1` clocks. It stops after `burst_len` strobes
// (0 = run until stopped), or when `stop` or `rst` is seen.
module strobe_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   interval,
    input  logic [CNT_W-1:0]   offset,
    input  logic [BURST_W-1:0] burst_len,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   ival_q,  ival_d;
    logic [CNT_W-1:0]   off_q,   off_d;
    logic [BURST_W-1:0] blen_q,  blen_d;
    logic [BURST_W-1:0] pcnt_q,  pcnt_d;
    logic               en_q,    en_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [BURST_W-1:0] pcnt_inc;
    logic               last_strobe;
    logic               delay_end;
    logic               period_end;

    // Helper terms: the strobe about to be emitted is the last one when the
    // incremented count reaches a non-zero burst length.
    always_comb begin
        pcnt_inc    = pcnt_q + BURST_W'(1);
        last_strobe = (blen_q != '0) && (pcnt_inc == blen_q);
        delay_end   = (cnt_q == off_q - CNT_W'(1));
        period_end  = (cnt_q == ival_q);
    end

    // Next-state, counter and output logic. The counter never passes the
    // latched interval, so it cannot wrap even at the all-ones interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ival_d  = ival_q;
        off_d   = off_q;
        blen_d  = blen_q;
        pcnt_d  = pcnt_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // stop blocks a start in the same cycle.
                if (start && !stop) begin
                    ival_d  = interval;
                    off_d   = offset;
                    blen_d  = burst_len;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    state_d = (offset != '0) ? DELAY : RUN;
                end
            end
            DELAY: begin
                if (stop) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (delay_end) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // stop beats a strobe or done due in the same cycle.
                if (stop) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (period_end) begin
                    cnt_d  = '0;
                    en_d   = 1'b1;
                    pcnt_d = pcnt_inc;
                    if (last_strobe) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ival_q  <= '0;
            off_q   <= '0;
            blen_q  <= '0;
            pcnt_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ival_q  <= ival_d;
            off_q   <= off_d;
            blen_q  <= blen_d;
            pcnt_q  <= pcnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Bench for strobe_gen: random runs scored against a strobe-schedule model.
module tb_strobe_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] interval, offset, burst_len;
    logic        en, busy, done;
    logic [15:0] pulse_cnt;

    // Narrow-counter instance for the full-scale interval case
    logic       c4_start;
    logic [3:0] c4_interval, c4_offset;
    logic [1:0] c4_burst;
    logic       c4_en, c4_busy, c4_done;
    logic [1:0] c4_pcnt;

    strobe_gen #(.CNT_W(16), .BURST_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .interval(interval), .offset(offset), .burst_len(burst_len),
        .en(en), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    strobe_gen #(.CNT_W(4), .BURST_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(c4_start), .stop(1'b0),
        .interval(c4_interval), .offset(c4_offset), .burst_len(c4_burst),
        .en(c4_en), .busy(c4_busy), .done(c4_done), .pulse_cnt(c4_pcnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          t;
        logic [15:0] pc;
        logic        dn;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the next scheduled one
    always @(negedge clk) begin
        exp_t e;
        check("done_without_en", 32'(done && !en), 32'd0);
        if (en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_en: en=1 after edge %0d, expected no strobe", edge_n);
            end else begin
                e = sb.pop_front();
                check("en_edge", 32'(edge_n), 32'(e.t));
                check("pulse_cnt_at_en", 32'(pulse_cnt), 32'(e.pc));
                check("done_at_en", 32'(done), 32'(e.dn));
            end
        end
    end

    // One run: start at edge E; arel>0 aborts (stop or rst) sampled at edge E+arel.
    task automatic run(input int iv, input int off, input int bl, input int arel, input bit use_rst);
        int  e_start, a_edge, f_edge, end_e, k, t;
        bit  ab;
        logic [15:0] pc_exp;

        // start together with stop in IDLE must be ignored
        start = 1'b1; stop = 1'b1; interval = 16'($urandom); offset = 16'($urandom);
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle_busy", 32'(busy), 32'd0);

        interval = 16'(iv); offset = 16'(off); burst_len = 16'(bl); start = 1'b1;
        e_start = edge_n + 1;
        a_edge  = e_start + arel;
        f_edge  = e_start + off + iv + 1 + (bl - 1) * (iv + 1);
        ab      = (arel != 0) && (bl == 0 || a_edge <= f_edge);
        end_e   = ab ? a_edge : f_edge;

        k = 0;
        forever begin
            t = e_start + off + iv + 1 + k * (iv + 1);
            if (bl != 0 && k >= bl) break;
            if (ab && t >= a_edge) break;
            sb.push_back('{t: t, pc: 16'(k + 1), dn: (bl != 0 && k == bl - 1)});
            k++;
        end
        pc_exp = (ab && use_rst) ? 16'd0 : 16'(k);

        tick();
        check("busy_after_start", 32'(busy), 32'd1);
        while (edge_n < end_e) begin
            start     = 1'($urandom_range(0, 1));
            interval  = 16'($urandom);
            offset    = 16'($urandom);
            burst_len = 16'($urandom);
            stop      = ab && !use_rst && (edge_n == a_edge - 1);
            rst       = ab && use_rst && (edge_n == a_edge - 1);
            tick();
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        @(negedge clk);
        #1;
        check("busy_after_end", 32'(busy), 32'd0);
        check("pulse_cnt_after_end", 32'(pulse_cnt), 32'(pc_exp));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        if (ab) begin
            check("en_after_abort", 32'(en), 32'd0);
            check("done_after_abort", 32'(done), 32'd0);
        end
        sb.delete();
    endtask

    initial begin
        int e4;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        interval = '0; offset = '0; burst_len = '0;
        c4_start = 1'b0; c4_interval = '0; c4_offset = '0; c4_burst = '0;
        repeat (3) tick();
        check("reset_en", 32'(en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pulse_cnt", 32'(pulse_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases from the intended usage
        run(3, 0, 0, 20, 1'b0);   // continuous, stopped
        run(0, 0, 4, 0, 1'b0);    // en every cycle, done with 4th
        run(2, 5, 3, 0, 1'b0);    // offset then 3 strobes
        run(3, 0, 0, 8, 1'b0);    // stop suppresses the strobe due at the same edge
        run(3, 0, 0, 6, 1'b1);    // reset mid-run
        run(1, 2, 2, 6, 1'b0);    // stop coincident with done

        for (int r = 0; r < 40; r++) begin
            int iv, off, bl, arel;
            bit ur;
            iv  = $urandom_range(0, 6);
            off = $urandom_range(0, 5);
            bl  = $urandom_range(0, 5);
            if (bl == 0) arel = $urandom_range(1, 40);
            else         arel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            ur = ($urandom_range(0, 3) == 0);
            run(iv, off, bl, arel, ur);
        end

        // Full-scale interval on a 4-bit counter: strobes after E+16 and E+32
        c4_interval = 4'd15; c4_offset = 4'd0; c4_burst = 2'd2; c4_start = 1'b1;
        e4 = edge_n + 1;
        tick();
        c4_start = 1'b0; c4_interval = 4'd3;
        while (edge_n < e4 + 34) begin
            check("c4_en", 32'(c4_en), 32'(edge_n == e4 + 16 || edge_n == e4 + 32));
            check("c4_done", 32'(c4_done), 32'(edge_n == e4 + 32));
            check("c4_busy", 32'(c4_busy), 32'(edge_n < e4 + 32));
            tick();
        end
        check("c4_pulse_cnt", 32'(c4_pcnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
